sipo_deserializer: RTL and testbench

Serial-In Parallel-Out deserializer. It sits directly downstream of the team's 4-bit PISO shift register and rebuilds WIDTH-bit words from its serial stream. Each completed word is presented on a valid/ready output with sticky overrun detection, so the parallel consumer can stall without silent data loss.

---
 rtl/sipo_pkg.sv | 16 +
 rtl/word_hold_reg.sv | 68 ++++++
 rtl/sipo_deserializer.sv | 127 ++++++++++++
 tb/tb_sipo_deserializer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO deserializer: FSM state encodings
// and the bit-counter width function.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Counter width for a WIDTH-bit word; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/word_hold_reg.sv
// Valid/ready holding register for completed words, with sticky overrun
// detection when a word completes while the held one cannot be replaced.
module word_hold_reg
#(
    parameter int WIDTH = 4
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_perr,
    input  logic             out_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             perr,
    output logic             overrun
);

    logic [WIDTH-1:0] data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             perr_reg, perr_next;
    logic             overrun_reg, overrun_next;
    logic             can_load;
    logic             drop;

    // A held word may be replaced in the same cycle it is being accepted.
    assign can_load = !valid_reg || out_ready;
    assign drop     = load_valid && !can_load;

    always_comb begin
        data_next  = data_reg;
        valid_next = valid_reg;
        perr_next  = perr_reg;
        if (load_valid) begin
            if (can_load) begin
                data_next  = load_data;
                perr_next  = load_perr;
                valid_next = 1'b1;
            end
        end else if (valid_reg && out_ready) begin
            valid_next = 1'b0;
        end
        // A fresh drop beats a simultaneous clear.
        overrun_next = drop || (overrun_reg && !overrun_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            perr_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            perr_reg    <= perr_next;
            overrun_reg <= overrun_next;
        end
    end

    assign data    = data_reg;
    assign valid   = valid_reg;
    assign perr    = perr_reg;
    assign overrun = overrun_reg;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer feeding a valid/ready word register.
// Define SIPO_PARITY_EN to expect an even-parity bit after every word.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             parity_err
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] sh_reg, sh_next;
    logic [WIDTH-1:0] sh_shifted;
    logic             word_done;
    logic [WIDTH-1:0] word_data;
    logic             word_perr;

    // Shift network: new bit enters at the MSB end or LSB end.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_in
                    assign sh_shifted[gi] = serial_in;
                end else begin : g_mv
                    assign sh_shifted[gi] = sh_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_in
                    assign sh_shifted[gi] = serial_in;
                end else begin : g_mv
                    assign sh_shifted[gi] = sh_reg[gi+1];
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sh_next    = sh_reg;
        word_done  = 1'b0;
        word_data  = sh_shifted;
        word_perr  = 1'b0;
        if (sync) begin
            state_next = IDLE;
            cnt_next   = '0;
            sh_next    = '0;
        end else if (bit_valid) begin
            case (state_reg)
                IDLE, SHIFT: begin
                    sh_next = sh_shifted;
                    if (cnt_reg == LAST_CNT) begin
                        cnt_next = '0;
`ifdef SIPO_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = IDLE;
                        word_done  = 1'b1;
`endif
                    end else begin
                        cnt_next   = cnt_reg + 1'b1;
                        state_next = SHIFT;
                    end
                end
`ifdef SIPO_PARITY_EN
                PARITY: begin
                    // The data word is already complete; this bit only checks it.
                    word_done  = 1'b1;
                    word_data  = sh_reg;
                    word_perr  = (^sh_reg) ^ serial_in;
                    state_next = IDLE;
                end
`endif
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sh_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sh_reg    <= sh_next;
        end
    end

    word_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (word_done),
        .load_data   (word_data),
        .load_perr   (word_perr),
        .out_ready   (out_ready),
        .overrun_clr (overrun_clr),
        .data        (parallel_out),
        .valid       (out_valid),
        .perr        (parity_err),
        .overrun     (overrun)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench: MSB-first and LSB-first instances share one stimulus
// stream; completed words are checked directly and through a scoreboard.
module tb_sipo_deserializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, serial_in, bit_valid, sync, out_ready, overrun_clr;
    logic [W-1:0] po_m, po_l;
    logic         ov_m, ov_l, ovr_m, ovr_l, pe_m, pe_l;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
        .sync(sync), .parallel_out(po_m), .out_valid(ov_m), .out_ready(out_ready),
        .overrun(ovr_m), .overrun_clr(overrun_clr), .parity_err(pe_m));

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
        .sync(sync), .parallel_out(po_l), .out_valid(ov_l), .out_ready(out_ready),
        .overrun(ovr_l), .overrun_clr(overrun_clr), .parity_err(pe_l));

    typedef struct {
        logic [3:0] exp_m;
        logic [3:0] exp_l;
        logic       perr;
    } sb_t;

    typedef struct {
        logic [3:0] seq;    // seq[3] is transmitted first
        bit         gaps;
        logic [3:0] exp_m;
        logic [3:0] exp_l;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("  ok   %s = %0h", name, act);
        end
    endtask

    // Runs at the falling edge: a word seen with valid&ready is consumed next edge.
    task automatic monitor();
        sb_t e;
        if (ov_m && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_word", ov_m, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check("sb_word_msb", po_m, e.exp_m);
                check("sb_word_lsb", po_l, e.exp_l);
                check("sb_valid_lsb", ov_l, 1'b1);
                check("sb_perr", pe_m, e.perr);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Sends one word; out_ready takes final_ready just before the completing bit.
    task automatic send_word(input logic [3:0] seq, input bit gaps, input logic final_ready);
        for (int i = 3; i >= 0; i--) begin
            if (gaps && i != 3) begin
                bit_valid = 1'b0;
                serial_in = ~seq[i];
                tick();
            end
`ifndef SIPO_PARITY_EN
            if (i == 0) out_ready = final_ready;
`endif
            bit_valid = 1'b1;
            serial_in = seq[i];
            tick();
            bit_valid = 1'b0;
        end
`ifdef SIPO_PARITY_EN
        if (gaps) tick();
        out_ready = final_ready;
        bit_valid = 1'b1;
        serial_in = ^seq;
        tick();
        bit_valid = 1'b0;
`endif
    endtask

    initial begin
        vecs[0] = '{seq: 4'b1011, gaps: 1'b0, exp_m: 4'b1011, exp_l: 4'b1101};
        vecs[1] = '{seq: 4'b1011, gaps: 1'b1, exp_m: 4'b1011, exp_l: 4'b1101};
        vecs[2] = '{seq: 4'b0011, gaps: 1'b0, exp_m: 4'b0011, exp_l: 4'b1100};
        vecs[3] = '{seq: 4'b1100, gaps: 1'b1, exp_m: 4'b1100, exp_l: 4'b0011};
        vecs[4] = '{seq: 4'b0110, gaps: 1'b1, exp_m: 4'b0110, exp_l: 4'b0110};
        vecs[5] = '{seq: 4'b1000, gaps: 1'b0, exp_m: 4'b1000, exp_l: 4'b0001};

        reset = 1'b1; serial_in = 1'b1; bit_valid = 1'b1; sync = 1'b0;
        out_ready = 1'b1; overrun_clr = 1'b0;
        tick();
        tick();
        check("rst_po_m", po_m, 4'b0000);
        check("rst_valid", ov_m, 1'b0);
        check("rst_overrun", ovr_m, 1'b0);
        check("rst_perr", pe_m, 1'b0);
        reset = 1'b0; bit_valid = 1'b0;
        tick();
        check("idle_valid", ov_m, 1'b0);

        // Table: latency right after the completing edge, then valid for exactly one cycle.
        for (int v = 0; v < 6; v++) begin
            send_word(vecs[v].seq, vecs[v].gaps, 1'b1);
            check($sformatf("vec%0d_valid", v), ov_m, 1'b1);
            check($sformatf("vec%0d_po_m", v), po_m, vecs[v].exp_m);
            check($sformatf("vec%0d_po_l", v), po_l, vecs[v].exp_l);
            sb_q.push_back('{exp_m: vecs[v].exp_m, exp_l: vecs[v].exp_l, perr: 1'b0});
            tick();
            check($sformatf("vec%0d_one_cycle", v), ov_m, 1'b0);
            check($sformatf("vec%0d_no_ovr", v), ovr_m, 1'b0);
        end

        // Overrun: second word dropped while the first is stalled.
        out_ready = 1'b0;
        send_word(4'b1010, 1'b0, 1'b0);
        sb_q.push_back('{exp_m: 4'b1010, exp_l: 4'b0101, perr: 1'b0});
        check("ovr_before", ovr_m, 1'b0);
        send_word(4'b0110, 1'b0, 1'b0);
        check("ovr_held_m", po_m, 4'b1010);
        check("ovr_held_l", po_l, 4'b0101);
        check("ovr_set_m", ovr_m, 1'b1);
        check("ovr_set_l", ovr_l, 1'b1);
        check("ovr_still_valid", ov_m, 1'b1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_cleared", ovr_m, 1'b0);
        out_ready = 1'b1;
        tick();
        check("ovr_drained", ov_m, 1'b0);

        // Clear in the same cycle as a fresh drop: set wins.
        out_ready = 1'b0;
        send_word(4'b1001, 1'b0, 1'b0);
        sb_q.push_back('{exp_m: 4'b1001, exp_l: 4'b1001, perr: 1'b0});
        overrun_clr = 1'b1;
        send_word(4'b0111, 1'b0, 1'b0);
        check("ovr_set_wins", ovr_m, 1'b1);
        out_ready = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clr_drain", ovr_m, 1'b0);

        // Replace-on-accept: valid stays high across the handover.
        out_ready = 1'b0;
        send_word(4'b0011, 1'b0, 1'b0);
        sb_q.push_back('{exp_m: 4'b0011, exp_l: 4'b1100, perr: 1'b0});
        send_word(4'b1100, 1'b0, 1'b1);
        check("b2b_valid", ov_m, 1'b1);
        check("b2b_po_m", po_m, 4'b1100);
        check("b2b_no_ovr", ovr_m, 1'b0);
        sb_q.push_back('{exp_m: 4'b1100, exp_l: 4'b0011, perr: 1'b0});
        tick();
        check("b2b_drained", ov_m, 1'b0);

        // sync discards a partial word; a concurrent bit is dropped.
        bit_valid = 1'b1; serial_in = 1'b1; tick();
        serial_in = 1'b0; tick();
        sync = 1'b1; serial_in = 1'b0; tick();
        sync = 1'b0; bit_valid = 1'b0;
        send_word(4'b1111, 1'b0, 1'b1);
        check("sync_po_m", po_m, 4'b1111);
        check("sync_po_l", po_l, 4'b1111);
        sb_q.push_back('{exp_m: 4'b1111, exp_l: 4'b1111, perr: 1'b0});
        tick();

        // sync leaves a held word alone.
        out_ready = 1'b0;
        send_word(4'b0101, 1'b0, 1'b0);
        sb_q.push_back('{exp_m: 4'b0101, exp_l: 4'b1010, perr: 1'b0});
        sync = 1'b1; tick(); sync = 1'b0;
        check("sync_hold_valid", ov_m, 1'b1);
        check("sync_hold_po", po_m, 4'b0101);
        out_ready = 1'b1;
        tick();

        // Reset mid-word with a word held and overrun set.
        out_ready = 1'b0;
        send_word(4'b0110, 1'b0, 1'b0);
        send_word(4'b0001, 1'b0, 1'b0);
        bit_valid = 1'b1; serial_in = 1'b1; tick();
        serial_in = 1'b0; tick();
        reset = 1'b1; bit_valid = 1'b0;
        tick();
        check("rst2_po_m", po_m, 4'b0000);
        check("rst2_po_l", po_l, 4'b0000);
        check("rst2_valid", ov_m, 1'b0);
        check("rst2_overrun", ovr_m, 1'b0);
        check("rst2_perr", pe_l, 1'b0);
        reset = 1'b0;
        sb_q.delete();
        out_ready = 1'b1;
        send_word(4'b1111, 1'b0, 1'b1);
        check("rst2_po_after", po_m, 4'b1111);
        sb_q.push_back('{exp_m: 4'b1111, exp_l: 4'b1111, perr: 1'b0});
        tick();

`ifdef SIPO_PARITY_EN
        // Parity: word appears only after the parity bit.
        for (int p = 0; p < 2; p++) begin
            for (int i = 3; i >= 0; i--) begin
                bit_valid = 1'b1;
                serial_in = (i == 2) ? 1'b0 : 1'b1;
                tick();
            end
            bit_valid = 1'b0;
            check($sformatf("par%0d_wait", p), ov_m, 1'b0);
            bit_valid = 1'b1; serial_in = (p == 0) ? 1'b1 : 1'b0;
            tick();
            bit_valid = 1'b0;
            check($sformatf("par%0d_valid", p), ov_m, 1'b1);
            check($sformatf("par%0d_po", p), po_m, 4'b1011);
            check($sformatf("par%0d_err_m", p), pe_m, (p == 0) ? 1'b0 : 1'b1);
            check($sformatf("par%0d_err_l", p), pe_l, (p == 0) ? 1'b0 : 1'b1);
            sb_q.push_back('{exp_m: 4'b1011, exp_l: 4'b1101, perr: (p == 0) ? 1'b0 : 1'b1});
            tick();
        end
`endif

        tick();
        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
